// File: rtl/fetch_queue.sv
// fetch_queue
//   Generates word-addressed fetch PCs, fetches instructions from a
//   variable-latency instruction memory (req/gnt/rvalid handshake, one
//   request outstanding at most), and buffers {pc, instr} pairs in a
//   DEPTH-entry queue that decode drains over a valid/ready handshake.
//   PC-select redirects (execute / EPC / error handler) flush the queue;
//   a response still in flight at the redirect is discarded.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_pcsrc             redirect select: 00 none, 01 execute, 10 EPC, 11 error
//   i_execute           branch/jump target
//   i_epc_to_pc         exception return address
//   i_error_handler     exception vector
//   o_imem_req/addr     fetch request and its word address
//   i_imem_gnt          request accepted this cycle
//   i_imem_rvalid/rdata response (one per granted request)
//   o_fetch_valid       queue head valid
//   o_fetch_pc/instr    head entry
//   i_fetch_ready       decode accepts head
module fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_pcsrc,
  input  logic [ADDR_W-1:0] i_execute,
  input  logic [ADDR_W-1:0] i_epc_to_pc,
  input  logic [ADDR_W-1:0] i_error_handler,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_fetch_valid,
  output logic [ADDR_W-1:0] o_fetch_pc,
  output logic [DATA_W-1:0] o_fetch_instr,
  input  logic              i_fetch_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] req_pc_reg;     // address of the request in flight
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              outstanding;
  logic [CNT_W:0]    in_use;
  logic              credit;
  logic              grant;
  logic              enq;
  logic              deq;

  // ---------------------------------------------------------------------
  // Redirect target selection
  // ---------------------------------------------------------------------
  assign redirect = (i_pcsrc != 2'b00);

  always_comb begin
    redirect_pc = fetch_pc_reg;
    case (i_pcsrc)
      2'b01:   redirect_pc = i_execute;
      2'b10:   redirect_pc = i_epc_to_pc;
      2'b11:   redirect_pc = i_error_handler;
      default: redirect_pc = fetch_pc_reg;
    endcase
  end

  // A slot is reserved for the outstanding request so the queue can never
  // overflow when its response lands.
  assign outstanding = (state_reg != ST_REQ);
  assign in_use      = {1'b0, count_reg} + {{CNT_W{1'b0}}, outstanding};
  assign credit      = (in_use < (CNT_W+1)'(DEPTH));

  assign grant = o_imem_req && i_imem_gnt;
  // A redirect kills the returning data and ignores decode's dequeue.
  assign enq   = (state_reg == ST_WAIT) && i_imem_rvalid && !redirect;
  assign deq   = o_fetch_valid && i_fetch_ready && !redirect;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= ST_REQ;
    else          state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_REQ:   if (grant) state_next = redirect ? ST_DRAIN : ST_WAIT;
      // A response coincident with a redirect still retires the request.
      ST_WAIT:  if (i_imem_rvalid) state_next = ST_REQ;
                else if (redirect) state_next = ST_DRAIN;
      ST_DRAIN: if (i_imem_rvalid) state_next = ST_REQ;
      default:  state_next = ST_REQ;
    endcase
  end

  // FSM: outputs. The request is masked while reset is held so the bus
  // sees no request until the fetch unit is out of reset.
  always_comb begin
    o_imem_req  = (state_reg == ST_REQ) && credit && i_rst_n;
    o_imem_addr = fetch_pc_reg;
  end

  // ---------------------------------------------------------------------
  // Fetch PC and in-flight address
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= '0;
    end else begin
      if (redirect)   fetch_pc_reg <= redirect_pc;
      else if (grant) fetch_pc_reg <= fetch_pc_reg + 1'b1;  // wraps naturally
      if (grant)      req_pc_reg   <= fetch_pc_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Queue pointers and occupancy
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Queue storage, one register pair per entry
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          pc_mem[gi]    <= '0;
          instr_mem[gi] <= '0;
        end else if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
          pc_mem[gi]    <= req_pc_reg;
          instr_mem[gi] <= i_imem_rdata;
        end
      end
    end
  endgenerate

  // Head is read straight from registered storage; it only changes on a
  // dequeue or flush, so it holds while valid && !ready.
  assign o_fetch_valid = (count_reg != '0);
  assign o_fetch_pc    = pc_mem[rd_ptr_reg];
  assign o_fetch_instr = instr_mem[rd_ptr_reg];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pcsrc;
  logic [31:0] execute, epc, handler;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_pc, fetch_instr;
  logic        fetch_ready;

  int total = 0;
  int bad   = 0;

  // Memory responder state: a grant seen at an edge produces rvalid in the
  // following cycle when auto_mem is set.
  logic        auto_mem;
  logic        granted;
  logic [31:0] gaddr;

  fetch_queue #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h100)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pcsrc        (pcsrc),
    .i_execute      (execute),
    .i_epc_to_pc    (epc),
    .i_error_handler(handler),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_gnt     (imem_gnt),
    .i_imem_rvalid  (imem_rvalid),
    .i_imem_rdata   (imem_rdata),
    .o_fetch_valid  (fetch_valid),
    .o_fetch_pc     (fetch_pc),
    .o_fetch_instr  (fetch_instr),
    .i_fetch_ready  (fetch_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    granted = imem_req && imem_gnt;
    gaddr   = imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rvalid = granted;
      imem_rdata  = instr_of(gaddr);
    end
  endtask

  // Run until n entries have been accepted by decode, checking each one.
  task automatic accept(input logic [31:0] start, input int n);
    logic [31:0] exp;
    int got;
    int guard;
    exp = start; got = 0; guard = 0;
    while (got < n && guard < 60) begin
      if (fetch_valid && fetch_ready) begin
        chk("acc_pc", fetch_pc, exp);
        chk("acc_instr", fetch_instr, instr_of(exp));
        $display("accept pc=%h instr=%h", fetch_pc, fetch_instr);
        exp++;
        got++;
      end
      cyc();
      guard++;
    end
    if (got < n) chk("acc_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    rst_n = 1'b0; pcsrc = 2'b00; execute = '0; epc = '0; handler = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; fetch_ready = 1'b1;
    auto_mem = 1'b1; granted = 1'b0; gaddr = '0;

    // Reset state
    repeat (2) cyc();
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_pc",    fetch_pc, 32'h0);
    chk("rst_instr", fetch_instr, 32'h0);

    // Streaming from RESET_PC with a zero-wait memory
    rst_n = 1'b1; #1;
    chk("first_req",  32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h100);
    accept(32'h100, 3);

    // Backpressure: queue fills with exactly four entries, request drops
    rst_n = 1'b0; fetch_ready = 1'b0; #1;
    rst_n = 1'b1; #1;
    repeat (12) cyc();
    chk("full_valid", 32'(fetch_valid), 32'd1);
    chk("full_pc",    fetch_pc, 32'h100);
    chk("full_req",   32'(imem_req), 32'd0);
    repeat (3) cyc();
    chk("hold_pc",    fetch_pc, 32'h100);
    chk("hold_instr", fetch_instr, instr_of(32'h100));
    chk("hold_req",   32'(imem_req), 32'd0);
    fetch_ready = 1'b1; #1;
    chk("drain_pc",   fetch_pc, 32'h100);
    $display("accept pc=%h instr=%h", fetch_pc, fetch_instr);
    cyc();
    chk("resume_req",  32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h104);
    accept(32'h101, 3);

    // Redirect to execute target while 0x105 is outstanding
    auto_mem = 1'b0; imem_rvalid = 1'b0;
    pcsrc = 2'b01; execute = 32'h200;
    chk("wait_req",  32'(imem_req), 32'd0);
    chk("wait_head", fetch_pc, 32'h104);
    cyc();
    pcsrc = 2'b00;
    chk("flush_valid", 32'(fetch_valid), 32'd0);
    chk("drain_req",   32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = instr_of(32'h105);
    cyc();
    imem_rvalid = 1'b0; auto_mem = 1'b1;
    chk("stale_valid", 32'(fetch_valid), 32'd0);
    chk("redir_req",   32'(imem_req), 32'd1);
    chk("redir_addr",  imem_addr, 32'h200);
    accept(32'h200, 1);

    // Error-handler redirect coincident with rvalid: data dropped
    pcsrc = 2'b11; handler = 32'h80;
    chk("err_rv",   32'(imem_rvalid), 32'd1);
    chk("err_req0", 32'(imem_req), 32'd0);
    cyc();
    pcsrc = 2'b00;
    chk("err_valid", 32'(fetch_valid), 32'd0);
    chk("err_req",   32'(imem_req), 32'd1);
    chk("err_addr",  imem_addr, 32'h80);

    // EPC redirect coincident with rvalid
    cyc();
    pcsrc = 2'b10; epc = 32'h40;
    chk("epc_rv", 32'(imem_rvalid), 32'd1);
    cyc();
    pcsrc = 2'b00;
    chk("epc_valid", 32'(fetch_valid), 32'd0);
    chk("epc_addr",  imem_addr, 32'h40);

    // Ungranted request holds address, no PC increment
    imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("nognt_req",  32'(imem_req), 32'd1);
      chk("nognt_addr", imem_addr, 32'h40);
      cyc();
    end
    imem_gnt = 1'b1;
    chk("gnt_addr", imem_addr, 32'h40);
    cyc();
    chk("gnt_wait", 32'(imem_req), 32'd0);
    cyc();
    chk("gnt_pc",    fetch_pc, 32'h40);
    chk("gnt_instr", fetch_instr, instr_of(32'h40));
    chk("gnt_next",  imem_addr, 32'h41);

    // Asynchronous reset mid-WAIT, stale rvalid before first grant
    cyc();
    chk("midwait_req", 32'(imem_req), 32'd0);
    rst_n = 1'b0; #1;
    chk("arst_req",   32'(imem_req), 32'd0);
    chk("arst_valid", 32'(fetch_valid), 32'd0);
    chk("arst_pc",    fetch_pc, 32'h0);
    chk("arst_instr", fetch_instr, 32'h0);
    auto_mem = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    rst_n = 1'b1; #1;
    chk("rel_req",  32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h100);
    cyc();
    chk("rel_valid", 32'(fetch_valid), 32'd0);
    chk("rel_addr2", imem_addr, 32'h100);
    imem_rvalid = 1'b0; imem_gnt = 1'b1; auto_mem = 1'b1;
    accept(32'h100, 1);

    // PC wrap from all ones to zero
    pcsrc = 2'b01; execute = 32'hFFFF_FFFF;
    cyc();
    pcsrc = 2'b00;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFF);
    cyc();
    cyc();
    chk("wrap_next",  imem_addr, 32'h0);
    chk("wrap_valid", 32'(fetch_valid), 32'd1);
    chk("wrap_pc",    fetch_pc, 32'hFFFF_FFFF);
    chk("wrap_instr", fetch_instr, instr_of(32'hFFFF_FFFF));

    // Redirect on the same cycle as a grant: the response is drained
    pcsrc = 2'b01; execute = 32'h300;
    cyc();
    pcsrc = 2'b00;
    chk("gr_drain_req",   32'(imem_req), 32'd0);
    chk("gr_drain_valid", 32'(fetch_valid), 32'd0);
    cyc();
    chk("gr_after_valid", 32'(fetch_valid), 32'd0);
    chk("gr_after_req",   32'(imem_req), 32'd1);
    chk("gr_after_addr",  imem_addr, 32'h300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
